// File: rtl/key_entry_accumulator_pkg.sv
// Shared key codes, FSM state encoding and key classification helpers for the
// calculator's key-entry path (also reused by the keypad scanner and operator FSM).
package key_entry_accumulator_pkg;

  localparam int KEY_W = 5;

  typedef logic [KEY_W-1:0] key_code_t;

  localparam key_code_t KEY_CLEAR     = 5'd16;
  localparam key_code_t KEY_BACKSPACE = 5'd17;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  function automatic logic is_digit(key_code_t code);
    return code <= 5'd15;
  endfunction

  function automatic logic is_dec_digit(key_code_t code);
    return code <= 5'd9;
  endfunction

endpackage

// File: rtl/key_entry_accumulator_if.sv
// Key-event handshake between the keypad decoder (master) and the accumulator (slave).
interface key_entry_accumulator_if;
  import key_entry_accumulator_pkg::*;

  logic      key_valid;
  key_code_t key_code;
  logic      switch;
  logic      key_ready;

  modport master (
    output key_valid,
    output key_code,
    output switch,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  switch,
    output key_ready
  );

endinterface

// File: rtl/key_entry_accumulator_seq_div_by_ten.sv
// Sequential restoring divide-by-ten: one quotient bit per clock, MSB first.
// done pulses on the final iteration edge, with quotient already valid alongside it.
module seq_div_by_ten #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             run_q, run_d;
  logic [4:0]       trial;
  logic             q_bit;
  logic             last_iter;

  // The dividend shifts out of the top while quotient bits shift in at the bottom.
  assign trial     = {rem_q, shift_q[WIDTH-1]};
  assign q_bit     = (trial >= 5'd10);
  assign last_iter = run_q && (count_q == CNT_W'(WIDTH - 1));

  always_comb begin
    shift_d = shift_q;
    rem_d   = rem_q;
    count_d = count_q;
    run_d   = run_q;
    if (start) begin
      shift_d = dividend;
      rem_d   = 4'd0;
      count_d = '0;
      run_d   = 1'b1;
    end else if (run_q) begin
      shift_d = {shift_q[WIDTH-2:0], q_bit};
      rem_d   = q_bit ? 4'(trial - 5'd10) : 4'(trial);
      count_d = count_q + CNT_W'(1);
      if (last_iter) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      rem_q   <= 4'd0;
      count_q <= '0;
      run_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      rem_q   <= rem_d;
      count_q <= count_d;
      run_q   <= run_d;
    end
  end

  assign quotient = {shift_q[WIDTH-2:0], q_bit};
  assign done     = last_iter;

endmodule

// File: rtl/key_entry_accumulator.sv
// Turns decoded key events into the binary operand and sticky error flag shown
// on the seven-segment display; entry radix follows the display radix switch.
module key_entry_accumulator
  import key_entry_accumulator_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int unsigned DEC_LIMIT = 9999999
) (
  input  logic                    clock,
  input  logic                    reset_n,
  key_entry_accumulator_if.slave  key_if,
  output logic [WIDTH-1:0]        value,
  output logic                    error,
  output logic                    busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             error_q, error_d;

  logic             accept;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH+3:0] times_ten;
  logic [WIDTH-1:0] hex_append;

  assign key_if.key_ready = (state_q == IDLE);
  assign busy             = ~key_if.key_ready;
  assign accept           = key_if.key_valid && key_if.key_ready;

  // Widened so the x10 never wraps before the DEC_LIMIT guard has been applied.
  assign times_ten  = ({4'b0000, value_q} << 3) + ({4'b0000, value_q} << 1)
                    + {{WIDTH{1'b0}}, key_if.key_code[3:0]};
  assign hex_append = {value_q[WIDTH-5:0], key_if.key_code[3:0]};

  seq_div_by_ten #(
    .WIDTH (WIDTH)
  ) u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (div_start),
    .dividend (value_q),
    .quotient (div_quotient),
    .done     (div_done)
  );

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    error_d   = error_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (key_if.key_code == KEY_CLEAR) begin
            value_d = '0;
            error_d = 1'b0;
          end else if (!error_q) begin
            if (is_digit(key_if.key_code)) begin
              if (key_if.switch) begin
                if (is_dec_digit(key_if.key_code)) begin
                  if (value_q <= WIDTH'(DEC_LIMIT)) begin
                    value_d = WIDTH'(times_ten);
                  end else begin
                    error_d = 1'b1;
                  end
                end
              end else if (value_q[WIDTH-1:WIDTH-4] == 4'd0) begin
                value_d = hex_append;
              end else begin
                error_d = 1'b1;
              end
            end else if (key_if.key_code == KEY_BACKSPACE) begin
              if (!key_if.switch) begin
                value_d = value_q >> 4;
              end else if (value_q != '0) begin
                div_start = 1'b1;
                state_d   = DIV;
              end
            end
          end
        end
      end
      DIV: begin
        // value keeps the old operand until the full quotient is available.
        if (div_done) begin
          value_d = div_quotient;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      value_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      error_q <= error_d;
    end
  end

  assign value = value_q;
  assign error = error_q;

endmodule

// File: tb/tb_key_entry_accumulator.sv
// Scoreboard bench: the driver pushes model predictions with their due cycle,
// a negedge monitor checks the division window and pops each due prediction.
module tb_key_entry_accumulator;
  import key_entry_accumulator_pkg::*;

  typedef struct {
    logic [31:0] value;
    logic        err;
    int          due;
    bit          is_div;
    logic [31:0] old_value;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] value;
  logic        error;
  logic        busy;

  exp_t        pending[$];
  exp_t        mon_head;
  int          compared    = 0;
  int          mismatched  = 0;
  int          cycle_count = 0;
  longint      model_value = 0;
  bit          model_err   = 1'b0;
  int          r;
  logic [4:0]  rcode;
  bit          sw_cur;
  int          drain;

  key_entry_accumulator_if key_if ();

  key_entry_accumulator #(
    .WIDTH     (32),
    .DEC_LIMIT (9999999)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .key_if  (key_if),
    .value   (value),
    .error   (error),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle_count <= cycle_count + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cycle_count);
    end
  endtask

  // Reference behaviour taken straight from the key rules, in plain integer arithmetic.
  task automatic modelApply(input logic [4:0] code, input bit sw, output exp_t e);
    int lat;
    lat         = 1;
    e.is_div    = 1'b0;
    e.old_value = model_value[31:0];
    if (code == 5'd16) begin
      model_value = 0;
      model_err   = 1'b0;
    end else if (model_err) begin
      lat = 1;
    end else if (code <= 5'd15) begin
      if (sw) begin
        if (code < 5'd10) begin
          if (model_value <= 9999999) model_value = model_value * 10 + longint'(code);
          else model_err = 1'b1;
        end
      end else begin
        if (model_value < 64'h1000_0000) model_value = model_value * 16 + longint'(code);
        else model_err = 1'b1;
      end
    end else if (code == 5'd17) begin
      if (!sw) begin
        model_value = model_value / 16;
      end else if (model_value != 0) begin
        model_value = model_value / 10;
        e.is_div    = 1'b1;
        lat         = 33;
      end
    end
    e.value = model_value[31:0];
    e.err   = model_err;
    e.due   = cycle_count + lat;
  endtask

  // Called at a negedge; holds the key until accepted, returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [4:0] code, input bit sw);
    int   waited;
    exp_t e;
    waited             = 0;
    key_if.key_valid   = 1'b1;
    key_if.key_code    = code;
    key_if.switch      = sw;
    while (key_if.key_ready !== 1'b1 && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 200) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL key_accept_timeout: key_ready stuck at %0b, expected 1", key_if.key_ready);
      key_if.key_valid = 1'b0;
    end else begin
      modelApply(code, sw, e);
      pending.push_back(e);
      @(negedge clock);
      key_if.key_valid = 1'b0;
    end
  endtask

  task automatic pulseReset();
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    pending.delete();
    model_value = 0;
    model_err   = 1'b0;
    #1;
    checkOutput("async_reset_value", value, 32'd0);
    checkOutput("async_reset_error", 32'(error), 32'd0);
    checkOutput("async_reset_ready", 32'(key_if.key_ready), 32'd1);
    checkOutput("async_reset_busy", 32'(busy), 32'd0);
    @(negedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1 && pending.size() > 0) begin
      mon_head = pending[0];
      if (mon_head.is_div && cycle_count >= mon_head.due - 32 && cycle_count < mon_head.due) begin
        checkOutput("div_ready_low", 32'(key_if.key_ready), 32'd0);
        checkOutput("div_busy_high", 32'(busy), 32'd1);
        checkOutput("div_value_hold", value, mon_head.old_value);
      end else if (cycle_count == mon_head.due) begin
        checkOutput("value", value, mon_head.value);
        checkOutput("error", 32'(error), 32'(mon_head.err));
        checkOutput("ready_after_key", 32'(key_if.key_ready), 32'd1);
        void'(pending.pop_front());
      end
    end
  end

  initial begin
    reset_n          = 1'b0;
    key_if.key_valid = 1'b0;
    key_if.key_code  = 5'd0;
    key_if.switch    = 1'b0;
    #3;
    checkOutput("reset_value", value, 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    checkOutput("reset_ready", 32'(key_if.key_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    @(negedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] decimal 1,2,3");
    applyStimulus(5'd1, 1'b1);
    applyStimulus(5'd2, 1'b1);
    applyStimulus(5'd3, 1'b1);

    $display("[TB] decimal overflow, sticky error, clear");
    applyStimulus(KEY_CLEAR, 1'b1);
    for (int i = 1; i <= 8; i++) applyStimulus(5'(i), 1'b1);
    applyStimulus(5'd9, 1'b1);
    applyStimulus(KEY_BACKSPACE, 1'b1);
    applyStimulus(KEY_CLEAR, 1'b1);

    $display("[TB] hex fill, overflow, hex backspace");
    for (int i = 0; i < 8; i++) applyStimulus(5'd15, 1'b0);
    applyStimulus(5'd1, 1'b0);
    applyStimulus(KEY_CLEAR, 1'b0);
    applyStimulus(5'd10, 1'b0);
    applyStimulus(5'd11, 1'b0);
    applyStimulus(KEY_BACKSPACE, 1'b0);

    $display("[TB] decimal backspace with key held during division");
    applyStimulus(KEY_CLEAR, 1'b1);
    for (int i = 9; i >= 4; i--) applyStimulus(5'(i), 1'b1);
    applyStimulus(KEY_BACKSPACE, 1'b1);
    applyStimulus(5'd3, 1'b1);

    $display("[TB] reset during division");
    applyStimulus(KEY_CLEAR, 1'b1);
    for (int i = 9; i >= 4; i--) applyStimulus(5'(i), 1'b1);
    applyStimulus(KEY_BACKSPACE, 1'b1);
    repeat (9) @(negedge clock);
    pulseReset();
    applyStimulus(5'd7, 1'b1);

    $display("[TB] radix change between keys");
    applyStimulus(KEY_CLEAR, 1'b0);
    applyStimulus(5'd1, 1'b0);
    applyStimulus(5'd15, 1'b0);
    applyStimulus(5'd12, 1'b1);
    applyStimulus(KEY_BACKSPACE, 1'b1);
    applyStimulus(5'd20, 1'b1);

    $display("[TB] random key stream");
    sw_cur = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) sw_cur = ~sw_cur;
      r = int'($urandom_range(0, 99));
      if (r < 62) rcode = 5'($urandom_range(0, 15));
      else if (r < 68) rcode = KEY_CLEAR;
      else if (r < 90) rcode = KEY_BACKSPACE;
      else rcode = 5'($urandom_range(18, 31));
      applyStimulus(rcode, sw_cur);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end

    drain = 0;
    while (pending.size() > 0 && drain < 100) begin
      @(negedge clock);
      drain++;
    end
    if (pending.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d predictions outstanding, expected 0", pending.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
